// File: rtl/decode_latch_pkg.sv
// Shared constants, FSM state and the latched-field payload for the fetch->decode register.
package decode_latch_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DRD_W  = 6;

  localparam logic [OP_W-1:0]  NOP_OPCODE   = 6'h00;
  localparam logic [OP_W-1:0]  NOP_FUNCT    = 6'h15;
  localparam logic [REG_W-1:0] LINK_REG     = 5'd31;

  localparam logic [OP_W-1:0]  OP_RTYPE     = 6'h00;
  localparam logic [OP_W-1:0]  OP_FPU       = 6'h01;
  localparam logic [OP_W-1:0]  OP_JAL       = 6'h03;
  localparam logic [OP_W-1:0]  OP_JALR      = 6'h13;
  localparam logic [OP_W-1:0]  OP_ALUI_LO   = 6'h08;
  localparam logic [OP_W-1:0]  OP_ALUI_HI   = 6'h0F;
  localparam logic [OP_W-1:0]  OP_ALUI2_LO  = 6'h18;
  localparam logic [OP_W-1:0]  OP_ALUI2_HI  = 6'h1F;
  localparam logic [OP_W-1:0]  OP_LOAD_LO   = 6'h20;
  localparam logic [OP_W-1:0]  OP_LOAD_HI   = 6'h27;
  localparam logic [OP_W-1:0]  OP_LF        = 6'h26;
  localparam logic [OP_W-1:0]  OP_LD        = 6'h27;
  localparam logic [OP_W-1:0]  FP_FUNCT_MAX = 6'h0b;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   funct;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc_plus_four;
    logic [DRD_W-1:0]  decode_rd;
  } id_fields_t;

  // Canonical bubble: NOP encoding, no destination, not valid.
  function automatic id_fields_t bubble_fields();
    id_fields_t b;
    b        = '0;
    b.opcode = NOP_OPCODE;
    b.funct  = NOP_FUNCT;
    return b;
  endfunction

endpackage

// File: rtl/decode_latch_dest_decode.sv
// Destination-register decode: {fp_dst, dest reg}; MSB is the fp flag, 6'h00 means no destination.
module dest_decode
  import decode_latch_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [OP_W-1:0]  funct,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic [DRD_W-1:0] decode_rd_c
);

  logic             fp_dst;
  logic [REG_W-1:0] dst;

  always_comb begin
    fp_dst = ((op == OP_FPU) && (funct <= FP_FUNCT_MAX)) || (op == OP_LF) || (op == OP_LD);
    dst    = '0;
    if ((op == OP_RTYPE) || (op == OP_FPU)) begin
      dst = ((op == NOP_OPCODE) && (funct == NOP_FUNCT)) ? '0 : rd;
    end else if ((op == OP_JAL) || (op == OP_JALR)) begin
      dst = LINK_REG;
    end else if (((op >= OP_LOAD_LO) && (op <= OP_LOAD_HI)) ||
                 ((op >= OP_ALUI_LO) && (op <= OP_ALUI_HI)) ||
                 ((op >= OP_ALUI2_LO) && (op <= OP_ALUI2_HI))) begin
      dst = rs2;
    end
    // An integer write to R0 is no destination at all.
    decode_rd_c = (!fp_dst && (dst == '0)) ? '0 : {fp_dst, dst};
  end

endmodule

// File: rtl/decode_latch.sv
// Fetch->decode pipeline register with stall hold, flush squash FSM and saturating stall counter.
module decode_latch
  import decode_latch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [OP_W-1:0]   OpCode,
  input  logic [OP_W-1:0]   Function,
  input  logic [PC_W-1:0]   PCPlusFour,
  input  logic [REG_W-1:0]  Rs1,
  input  logic [REG_W-1:0]  Rs2,
  input  logic [REG_W-1:0]  Rd,
  input  logic [IMM_W-1:0]  Immediate,
  output logic [OP_W-1:0]   IdOpCode,
  output logic [OP_W-1:0]   IdFunction,
  output logic [REG_W-1:0]  IdRs1,
  output logic [REG_W-1:0]  IdRs2,
  output logic [REG_W-1:0]  IdRd,
  output logic [IMM_W-1:0]  IdImmediate,
  output logic              IdValid,
  output logic [OP_W-1:0]   DecodeOpCode,
  output logic [PC_W-1:0]   DecodePCPlusFour,
  output logic [DRD_W-1:0]  DecodeRd,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned     SQ_W      = 2;
  localparam logic [SQ_W-1:0] SQ_RELOAD = SQ_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  id_fields_t       bank_q, bank_d;
  id_fields_t       fetch_c;
  logic [DRD_W-1:0] decode_rd_c;

  dest_decode u_dest_decode (
    .op          (OpCode),
    .funct       (Function),
    .rs2         (Rs2),
    .rd          (Rd),
    .decode_rd_c (decode_rd_c)
  );

  // State register, squash counter, field bank and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      sq_cnt_q    <= '0;
      stall_cnt_q <= '0;
      bank_q      <= bubble_fields();
    end else begin
      state_q     <= state_d;
      sq_cnt_q    <= sq_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      bank_q      <= bank_d;
    end
  end

  // Next state: flush reloads the squash count, each unstalled squash cycle consumes one.
  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (flush) begin
      sq_cnt_d = SQ_RELOAD;
      state_d  = (SQ_RELOAD != '0) ? SQUASH : RUN;
    end else if (!stall && (state_q == SQUASH)) begin
      sq_cnt_d = sq_cnt_q - SQ_W'(1);
      if (sq_cnt_q == SQ_W'(1)) begin
        state_d = RUN;
      end
    end
  end

  // Output bank: flush beats stall; squash cycles load bubbles instead of fetch fields.
  always_comb begin
    fetch_c              = '0;
    fetch_c.valid        = 1'b1;
    fetch_c.opcode       = OpCode;
    fetch_c.funct        = Function;
    fetch_c.rs1          = Rs1;
    fetch_c.rs2          = Rs2;
    fetch_c.rd           = Rd;
    fetch_c.imm          = Immediate;
    fetch_c.pc_plus_four = PCPlusFour;
    fetch_c.decode_rd    = decode_rd_c;

    bank_d = bank_q;
    if (flush) begin
      bank_d = bubble_fields();
    end else if (!stall) begin
      bank_d = (state_q == SQUASH) ? bubble_fields() : fetch_c;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign IdOpCode         = bank_q.opcode;
  assign IdFunction       = bank_q.funct;
  assign IdRs1            = bank_q.rs1;
  assign IdRs2            = bank_q.rs2;
  assign IdRd             = bank_q.rd;
  assign IdImmediate      = bank_q.imm;
  assign IdValid          = bank_q.valid;
  assign DecodeOpCode     = bank_q.opcode;
  assign DecodePCPlusFour = bank_q.pc_plus_four;
  assign DecodeRd         = bank_q.decode_rd;
  assign StallCount       = stall_cnt_q;

endmodule

// File: tb/tb_decode_latch.sv
// Randomized bench for decode_latch against a cycle-level reference model, plus directed literal checks.
module tb_decode_latch;

  localparam int FC    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [5:0]  OpCode, Function;
  logic [31:0] PCPlusFour;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [15:0] Immediate;
  logic [5:0]  IdOpCode, IdFunction, DecodeOpCode, DecodeRd;
  logic [4:0]  IdRs1, IdRs2, IdRd;
  logic [15:0] IdImmediate;
  logic        IdValid;
  logic [31:0] DecodePCPlusFour;
  logic [CNT_W-1:0] StallCount;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what every output must show after the next rising edge.
  logic [5:0]  m_op, m_fn, m_drd;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [15:0] m_imm;
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_scnt, m_squash_left;

  logic [5:0]  op_tab [16];

  decode_latch #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .OpCode(OpCode), .Function(Function), .PCPlusFour(PCPlusFour),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Immediate(Immediate),
    .IdOpCode(IdOpCode), .IdFunction(IdFunction), .IdRs1(IdRs1), .IdRs2(IdRs2),
    .IdRd(IdRd), .IdImmediate(IdImmediate), .IdValid(IdValid),
    .DecodeOpCode(DecodeOpCode), .DecodePCPlusFour(DecodePCPlusFour),
    .DecodeRd(DecodeRd), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination rule stated directly on opcode numbers.
  function automatic logic [5:0] ref_drd(input int o, input int fn, input int rs2, input int rd);
    bit fp;
    int r;
    fp = (o == 1 && fn <= 11) || o == 38 || o == 39;
    if (o == 0 && fn == 21)                                                r = 0;
    else if (o == 0 || o == 1)                                             r = rd;
    else if (o == 3 || o == 19)                                            r = 31;
    else if ((o >= 32 && o <= 39) || (o >= 8 && o <= 15) || (o >= 24 && o <= 31)) r = rs2;
    else                                                                   r = 0;
    if (!fp && r == 0) return 6'h00;
    return 6'((fp ? 32 : 0) + r);
  endfunction

  function automatic void model_bubble();
    m_op = 6'h00; m_fn = 6'h15; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_imm = 0; m_pc = 0; m_valid = 0; m_drd = 0;
  endfunction

  function automatic void model_update();
    if (reset) begin
      model_bubble();
      m_scnt = 0;
      m_squash_left = 0;
      return;
    end
    if (stall && m_scnt < CMAX) m_scnt++;
    if (flush) begin
      model_bubble();
      m_squash_left = FC - 1;
    end else if (!stall) begin
      if (m_squash_left > 0) begin
        model_bubble();
        m_squash_left--;
      end else begin
        m_op = OpCode; m_fn = Function; m_rs1 = Rs1; m_rs2 = Rs2; m_rd = Rd;
        m_imm = Immediate; m_pc = PCPlusFour; m_valid = 1'b1;
        m_drd = ref_drd(int'(OpCode), int'(Function), int'(Rs2), int'(Rd));
      end
    end
  endfunction

  task automatic rand_fetch();
    OpCode     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
    case ($urandom_range(0, 2))
      0:       Function = 6'h15;
      1:       Function = 6'($urandom_range(0, 11));
      default: Function = 6'($urandom);
    endcase
    Rs1        = 5'($urandom);
    Rs2        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    Rd         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    Immediate  = 16'($urandom);
    PCPlusFour = $urandom;
  endtask

  task automatic set_fetch(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] d, input logic [31:0] pc);
    OpCode = op; Function = fn; Rs1 = a; Rs2 = b; Rd = d; Immediate = 16'h1234; PCPlusFour = pc;
  endtask

  // Apply one cycle: inputs and expected state are settled before the edge, bench resumes 3 after it.
  task automatic step(input bit r, input bit st, input bit fl);
    reset = r; stall = st; flush = fl;
    model_update();
    @(posedge clk);
    #3;
  endtask

  // Compare process: every output against the model, 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    check("IdOpCode",         32'(IdOpCode),     32'(m_op));
    check("IdFunction",       32'(IdFunction),   32'(m_fn));
    check("IdRs1",            32'(IdRs1),        32'(m_rs1));
    check("IdRs2",            32'(IdRs2),        32'(m_rs2));
    check("IdRd",             32'(IdRd),         32'(m_rd));
    check("IdImmediate",      32'(IdImmediate),  32'(m_imm));
    check("IdValid",          32'(IdValid),      32'(m_valid));
    check("DecodeOpCode",     32'(DecodeOpCode), 32'(m_op));
    check("DecodePCPlusFour", DecodePCPlusFour,  m_pc);
    check("DecodeRd",         32'(DecodeRd),     32'(m_drd));
    check("StallCount",       32'(StallCount),   32'(m_scnt));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_tab = '{6'h00, 6'h01, 6'h03, 6'h13, 6'h20, 6'h23, 6'h26, 6'h27,
               6'h08, 6'h0F, 6'h18, 6'h1F, 6'h2B, 6'h04, 6'h02, 6'h3F};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    m_scnt = 0; m_squash_left = 0;
    model_bubble();

    // Reset with random inputs, including stall and flush.
    for (int i = 0; i < 2; i++) begin
      rand_fetch();
      step(1'b1, 1'($urandom), 1'($urandom));
    end
    check("reset_IdValid",    32'(IdValid),    32'h0);
    check("reset_IdFunction", 32'(IdFunction), 32'h15);
    check("reset_DecodeRd",   32'(DecodeRd),   32'h0);
    check("reset_StallCount", 32'(StallCount), 32'h0);

    // add r3,r1,r2
    set_fetch(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h104);
    step(1'b0, 1'b0, 1'b0);
    check("add_IdRd",     32'(IdRd),     32'h3);
    check("add_DecodeRd", 32'(DecodeRd), 32'h03);
    check("add_PC",       DecodePCPlusFour, 32'h104);
    check("add_IdValid",  32'(IdValid),  32'h1);

    // lw r5 then 3 stalled cycles with changing inputs
    set_fetch(6'h23, 6'h00, 5'd7, 5'd5, 5'd0, 32'h108);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_fetch();
      step(1'b0, 1'b1, 1'b0);
    end
    check("lw_hold_op",     32'(IdOpCode),   32'h23);
    check("lw_DecodeRd",    32'(DecodeRd),   32'h05);
    check("lw_StallCount",  32'(StallCount), 32'h3);

    // Flush with FLUSH_CYCLES=2: two bubbles then the next fetch is latched.
    rand_fetch();
    step(1'b0, 1'b0, 1'b1);
    check("flush_b1_valid", 32'(IdValid),    32'h0);
    check("flush_b1_funct", 32'(IdFunction), 32'h15);
    rand_fetch();
    step(1'b0, 1'b0, 1'b0);
    check("flush_b2_valid", 32'(IdValid),    32'h0);
    set_fetch(6'h08, 6'h00, 5'd1, 5'd9, 5'd0, 32'h200);
    step(1'b0, 1'b0, 1'b0);
    check("flush_f3_valid", 32'(IdValid),    32'h1);
    check("flush_f3_op",    32'(IdOpCode),   32'h08);
    check("flush_f3_drd",   32'(DecodeRd),   32'h09);

    // Flush together with stall, then a stall inside the squash window.
    rand_fetch();
    step(1'b0, 1'b1, 1'b1);
    check("fs_valid",       32'(IdValid), 32'h0);
    rand_fetch();
    step(1'b0, 1'b1, 1'b0);
    check("sq_stall_valid", 32'(IdValid), 32'h0);
    rand_fetch();
    step(1'b0, 1'b0, 1'b0);
    check("sq_b2_valid",    32'(IdValid), 32'h0);
    set_fetch(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 32'h300);
    step(1'b0, 1'b0, 1'b0);
    check("sq_after_valid", 32'(IdValid), 32'h1);
    check("jal_DecodeRd",   32'(DecodeRd), 32'h1F);

    set_fetch(6'h01, 6'h00, 5'd1, 5'd2, 5'd4, 32'h304);
    step(1'b0, 1'b0, 1'b0);
    check("addf_DecodeRd",  32'(DecodeRd), 32'h24);
    set_fetch(6'h2B, 6'h00, 5'd1, 5'd6, 5'd6, 32'h308);
    step(1'b0, 1'b0, 1'b0);
    check("sw_DecodeRd",    32'(DecodeRd), 32'h00);
    set_fetch(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'h30C);
    step(1'b0, 1'b0, 1'b0);
    check("r0_DecodeRd",    32'(DecodeRd), 32'h00);
    set_fetch(6'h00, 6'h15, 5'd1, 5'd2, 5'd7, 32'h310);
    step(1'b0, 1'b0, 1'b0);
    check("nop_DecodeRd",   32'(DecodeRd), 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_fetch();
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 99) < 30),
           1'($urandom_range(0, 99) < 10));
    end

    // Stall counter saturation from a fresh reset.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      rand_fetch();
      step(1'b0, 1'b1, 1'b0);
      if (i == 13) check("sat_minus1", 32'(StallCount), 32'hE);
      if (i == 14) check("sat_reach",  32'(StallCount), 32'hF);
    end
    check("sat_hold", 32'(StallCount), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
